// File: rtl/seq_pkg.sv
// Shared types and constants for the hardwired instruction sequencer.
package seq_pkg;

    localparam int unsigned WORDW = 32;
    localparam int unsigned OPW   = 5;
    localparam int unsigned REGW  = 4;
    localparam int unsigned NREG  = 16;
    localparam int unsigned ALUW  = 13;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    typedef logic [OPW-1:0] opcode_t;

    localparam opcode_t OP_AND  = 5'd0;
    localparam opcode_t OP_OR   = 5'd1;
    localparam opcode_t OP_ADD  = 5'd2;
    localparam opcode_t OP_SUB  = 5'd3;
    localparam opcode_t OP_MUL  = 5'd4;
    localparam opcode_t OP_DIV  = 5'd5;
    localparam opcode_t OP_SHR  = 5'd6;
    localparam opcode_t OP_SHL  = 5'd7;
    localparam opcode_t OP_ROR  = 5'd8;
    localparam opcode_t OP_ROL  = 5'd9;
    localparam opcode_t OP_NEG  = 5'd10;
    localparam opcode_t OP_NOT  = 5'd11;
    localparam opcode_t OP_SHRA = 5'd12;
    localparam opcode_t OP_HALT = 5'd31;

    // alu_sel bit positions coincide with the opcode values of the ALU ops
    localparam int unsigned ALU_AND  = 0;
    localparam int unsigned ALU_OR   = 1;
    localparam int unsigned ALU_ADD  = 2;
    localparam int unsigned ALU_SUB  = 3;
    localparam int unsigned ALU_MUL  = 4;
    localparam int unsigned ALU_DIV  = 5;
    localparam int unsigned ALU_SHR  = 6;
    localparam int unsigned ALU_SHL  = 7;
    localparam int unsigned ALU_ROR  = 8;
    localparam int unsigned ALU_ROL  = 9;
    localparam int unsigned ALU_NEG  = 10;
    localparam int unsigned ALU_NOT  = 11;
    localparam int unsigned ALU_SHRA = 12;

    function automatic logic is_legal(input opcode_t op);
        return op <= OP_SHRA;
    endfunction

    function automatic logic is_unary(input opcode_t op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input opcode_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface instr_sequencer_if;
    import seq_pkg::*;

    logic             run;
    logic             mem_ready;
    logic [WORDW-1:0] IRdataout;

    logic             PCout, MDRout, Zhighout, Zlowout;
    logic [NREG-1:0]  Rout;
    logic [NREG-1:0]  Rin;
    logic             MARin, MDRin, IRin, Yin, Zin, HIin, LOin, PCin;
    logic             Read;
    logic             IncPC;
    logic [ALUW-1:0]  alu_sel;
    logic             busy;
    logic             halted;

    modport master (
        input  run, mem_ready, IRdataout,
        output PCout, MDRout, Zhighout, Zlowout, Rout, Rin,
               MARin, MDRin, IRin, Yin, Zin, HIin, LOin, PCin,
               Read, IncPC, alu_sel, busy, halted
    );

    modport slave (
        output run, mem_ready, IRdataout,
        input  PCout, MDRout, Zhighout, Zlowout, Rout, Rin,
               MARin, MDRin, IRin, Yin, Zin, HIin, LOin, PCin,
               Read, IncPC, alu_sel, busy, halted
    );
endinterface

// File: rtl/reg_decoder_4_16.sv
// 4-to-16 one-hot register select decoder with enable.
module reg_decoder_4_16
    import seq_pkg::*;
(
    input  logic            en,
    input  logic [REGW-1:0] idx,
    output logic [NREG-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot = NREG'(1) << idx;
    end
endmodule

// File: rtl/instr_sequencer.sv
// Hardwired fetch/execute control unit for the single-bus 32-bit datapath.
module instr_sequencer
    import seq_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    instr_sequencer_if.master  bus
);
    state_t          state;
    state_t          state_nxt;
    opcode_t         op;
    logic [REGW-1:0] ra, rb, rc;
    logic            rout_en, rin_en;
    logic [REGW-1:0] rout_idx, rin_idx;
    logic            unused_ir;

    assign op        = opcode_t'(bus.IRdataout[31:27]);
    assign ra        = bus.IRdataout[26:23];
    assign rb        = bus.IRdataout[22:19];
    assign rc        = bus.IRdataout[18:15];
    assign unused_ir = ^bus.IRdataout[14:0];

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.run) state_nxt = T0;
            T0:      state_nxt = T1;
            T1:      if (bus.mem_ready) state_nxt = T2;
            T2:      state_nxt = T3;
            T3: begin
                if (op == OP_HALT)   state_nxt = HALT;
                else if (!is_legal(op)) state_nxt = T0;
                else                 state_nxt = T4;
            end
            T4:      state_nxt = T5;
            T5:      state_nxt = is_muldiv(op) ? T6 : T0;
            T6:      state_nxt = T0;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore strobe decode; only T3..T5 look at the IR fields
    always_comb begin
        bus.PCout    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.PCin     = 1'b0;
        bus.Read     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.alu_sel  = '0;
        bus.busy     = (state != IDLE) && (state != HALT);
        bus.halted   = (state == HALT);
        rout_en      = 1'b0;
        rout_idx     = rb;
        rin_en       = 1'b0;
        rin_idx      = ra;
        case (state)
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
            end
            T1: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                if (is_legal(op)) begin
                    rout_en = 1'b1;
                    bus.Yin = 1'b1;
                end
            end
            T4: begin
                rout_en     = 1'b1;
                rout_idx    = is_unary(op) ? rb : rc;
                bus.alu_sel = ALUW'(1) << op;
                bus.Zin     = 1'b1;
            end
            T5: begin
                bus.Zlowout = 1'b1;
                if (is_muldiv(op)) bus.LOin = 1'b1;
                else               rin_en   = 1'b1;
            end
            T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    reg_decoder_4_16 u_rout_dec (
        .en     (rout_en),
        .idx    (rout_idx),
        .onehot (bus.Rout)
    );

    reg_decoder_4_16 u_rin_dec (
        .en     (rin_en),
        .idx    (rin_idx),
        .onehot (bus.Rin)
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized cycle-by-cycle check of instr_sequencer against a per-instruction step model.
module tb_instr_sequencer;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct packed {
        logic        pcout, mdrout, zhighout, zlowout;
        logic [15:0] rout;
        logic [15:0] rin;
        logic        marin, mdrin, irin, yin, zin, hiin, loin, pcin, read, incpc;
        logic [12:0] alu_sel;
        logic        busy, halted;
    } obs_t;

    typedef struct packed {
        obs_t        o;
        logic        mr;
        logic        run;
        logic        clr;
        logic [31:0] ir;
    } step_t;

    step_t       sq[$];
    string       tq[$];
    logic [31:0] cur_ir;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.pcout = bus.PCout;    o.mdrout = bus.MDRout;
        o.zhighout = bus.Zhighout; o.zlowout = bus.Zlowout;
        o.rout = bus.Rout;      o.rin = bus.Rin;
        o.marin = bus.MARin;    o.mdrin = bus.MDRin;  o.irin = bus.IRin;
        o.yin = bus.Yin;        o.zin = bus.Zin;      o.hiin = bus.HIin;
        o.loin = bus.LOin;      o.pcin = bus.PCin;    o.read = bus.Read;
        o.incpc = bus.IncPC;    o.alu_sel = bus.alu_sel;
        o.busy = bus.busy;      o.halted = bus.halted;
        return o;
    endfunction

    function automatic obs_t blank(input logic bsy);
        obs_t o = '0;
        o.busy = bsy;
        return o;
    endfunction

    task automatic push(input string tag, input obs_t o, input logic mr, input logic run,
                        input logic c);
        step_t s;
        s.o = o; s.mr = mr; s.run = run; s.clr = c; s.ir = cur_ir;
        sq.push_back(s);
        tq.push_back(tag);
    endtask

    // IDLE / reset cycle: everything low, run explicitly chosen
    task automatic push_idle(input string tag, input logic run, input logic c);
        push(tag, blank(1'b0), 1'($urandom), run, c);
    endtask

    // Expected strobes for one instruction, written straight from the step table
    task automatic model_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [3:0] rc, input int waits);
        obs_t o;
        int   src;
        cur_ir = {op, ra, rb, rc, 15'($urandom)};
        o = blank(1'b1); o.pcout = 1; o.marin = 1; o.incpc = 1;
        push("T0", o, 1'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i <= waits; i++) begin
            o = blank(1'b1); o.read = 1; o.mdrin = 1;
            push("T1", o, (i == waits), 1'($urandom), 1'b0);
        end
        o = blank(1'b1); o.mdrout = 1; o.irin = 1;
        push("T2", o, 1'($urandom), 1'($urandom), 1'b0);
        if (op > 5'd12) begin
            push((op == 5'd31) ? "T3_halt" : "T3_nop", blank(1'b1), 1'($urandom),
                 1'($urandom), 1'b0);
            return;
        end
        o = blank(1'b1); o.rout = 16'd1 << rb; o.yin = 1;
        push("T3", o, 1'($urandom), 1'($urandom), 1'b0);
        src = (op == 5'd10 || op == 5'd11) ? int'(rb) : int'(rc);
        o = blank(1'b1); o.rout = 16'd1 << src; o.alu_sel = 13'd1 << op; o.zin = 1;
        push("T4", o, 1'($urandom), 1'($urandom), 1'b0);
        o = blank(1'b1); o.zlowout = 1;
        if (op == 5'd4 || op == 5'd5) begin
            o.loin = 1;
            push("T5_lo", o, 1'($urandom), 1'($urandom), 1'b0);
            o = blank(1'b1); o.zhighout = 1; o.hiin = 1;
            push("T6", o, 1'($urandom), 1'($urandom), 1'b0);
        end else begin
            o.rin = 16'd1 << ra;
            push("T5_wb", o, 1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    task automatic model_halt(input int hold);
        obs_t o;
        model_instr(5'd31, 4'($urandom), 4'($urandom), 4'($urandom), 0);
        o = blank(1'b0); o.halted = 1;
        for (int i = 0; i < hold; i++)
            push("HALT", o, 1'($urandom), 1'(i & 1), 1'b0);
        push("HALT_clr", o, 1'($urandom), 1'($urandom), 1'b1);
        push_idle("IDLE_after_clr", 1'b0, 1'b0);
        push_idle("IDLE_start", 1'b1, 1'b0);
    endtask

    // Instruction cut short by clr on its k-th cycle
    task automatic model_abort(input logic [4:0] op, input int waits, input int k);
        int base = sq.size();
        model_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), waits);
        if (base + k < sq.size()) begin
            sq = sq[0:base+k];
            tq = tq[0:base+k];
        end
        sq[sq.size()-1].clr = 1'b1;
        push_idle("IDLE_after_abort", 1'b0, 1'b0);
        push_idle("IDLE_start", 1'b1, 1'b0);
    endtask

    task automatic drain();
        step_t s;
        string t;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            t = tq.pop_front();
            bus.mem_ready = s.mr;
            bus.run       = s.run;
            bus.IRdataout = s.ir;
            clr           = s.clr;
            @(negedge clk);
            check(t, 64'(sample()), 64'(s.o));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [4:0] rand_op();
        int r = int'($urandom_range(0, 9));
        if (r == 0) return 5'($urandom_range(13, 30));
        return 5'($urandom_range(0, 12));
    endfunction

    initial begin
        clr = 1'b1;
        bus.run = 1'b0;
        bus.mem_ready = 1'b0;
        bus.IRdataout = '0;
        cur_ir = '0;
        @(posedge clk);
        #1;
        push_idle("reset", 1'($urandom), 1'b1);
        push_idle("reset", 1'($urandom), 1'b1);
        push_idle("IDLE_wait", 1'b0, 1'b0);
        push_idle("IDLE_start", 1'b1, 1'b0);
        model_instr(5'd2, 4'd3, 4'd1, 4'd2, 0);
        model_instr(5'd4, 4'd0, 4'd5, 4'd6, 0);
        model_instr(5'd5, 4'd15, 4'd15, 4'd0, 1);
        model_instr(5'd3, 4'd7, 4'd7, 4'd7, 3);
        model_instr(5'd10, 4'd2, 4'd9, 4'd4, 0);
        model_instr(5'd11, 4'd0, 4'd0, 4'd15, 2);
        model_instr(5'd12, 4'd14, 4'd13, 4'd12, 0);
        model_instr(5'd20, 4'd1, 4'd1, 4'd1, 0);
        model_instr(5'd13, 4'd1, 4'd1, 4'd1, 2);
        drain();
        model_abort(5'd3, 0, 4);
        model_abort(5'd3, 2, 6);
        drain();
        model_halt(20);
        drain();
        for (int n = 0; n < 60; n++) begin
            model_instr(rand_op(), 4'($urandom), 4'($urandom), 4'($urandom),
                        int'($urandom_range(0, 3)));
            if (n % 15 == 14)
                model_abort(rand_op(), int'($urandom_range(0, 2)), int'($urandom_range(0, 8)));
            drain();
        end
        model_halt(int'($urandom_range(3, 10)));
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
